// File: rtl/xbar_write_order_tracker.sv
// xbar_write_order_tracker: per-slave AW-order queue steering W beats from source masters; optional WLAST/length check under XBAR_WLAST_CHECK_EN
module xbar_write_order_tracker #(
    parameter  int masters   = 2,
    parameter  int LEN_WIDTH = 4,
    parameter  int depth     = 4,
    localparam int MW        = (masters > 1) ? $clog2(masters) : 1,
    localparam int AW        = $clog2(depth),
    localparam int PW        = AW + 1
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    input  logic                 aw_accept,
    input  logic [MW-1:0]        aw_master,
    input  logic [LEN_WIDTH-1:0] aw_len,
    output logic                 aw_block,
    output logic                 w_src_valid,
    output logic [MW-1:0]        w_src_master,
    input  logic                 w_beat,
    input  logic                 w_last,
    output logic [PW-1:0]        outstanding,
    output logic                 w_err,
    input  logic                 err_clr
);

    typedef struct packed {
        logic [MW-1:0]        master;
        logic [LEN_WIDTH-1:0] len;
    } entry_t;

    entry_t               mem_q [depth];
    entry_t               mem_d [depth];
    logic [PW-1:0]        wr_q, wr_d, rd_q, rd_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic                 w_err_q, w_err_d;
    logic                 empty, full, push, beat, retire;
    entry_t               head;

    assign empty        = (wr_q == rd_q);
    assign full         = (wr_q[PW-1] != rd_q[PW-1]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head         = mem_q[rd_q[AW-1:0]];
    assign push         = aw_accept & ~full;
    assign beat         = w_beat & ~empty;
    assign aw_block     = full;
    assign w_src_valid  = ~empty;
    assign w_src_master = empty ? '0 : head.master;
    assign outstanding  = wr_q - rd_q;
    assign w_err        = w_err_q;

`ifdef XBAR_WLAST_CHECK_EN
    logic len_hit;
    assign len_hit = (cnt_q == head.len);
    assign retire  = beat & (w_last | len_hit);
    // Sticky error on WLAST/length disagreement or a beat with nothing queued; a new error beats a clear
    always_comb begin
        w_err_d = ((beat & (w_last != len_hit)) | (w_beat & empty)) | (w_err_q & ~err_clr);
    end
`else
    logic                 unused_err_clr;
    logic [LEN_WIDTH-1:0] unused_head_len;
    assign unused_err_clr  = err_clr;
    assign unused_head_len = head.len;
    assign retire          = beat & w_last;
    // Without the length check there is no error source
    always_comb begin
        w_err_d = 1'b0;
    end
`endif

    // Next-state for pointers, beat counter and queue storage
    always_comb begin
        wr_d  = push ? wr_q + 1'b1 : wr_q;
        rd_d  = retire ? rd_q + 1'b1 : rd_q;
        cnt_d = retire ? '0 : (beat ? cnt_q + 1'b1 : cnt_q);
        mem_d = mem_q;
        if (push) mem_d[wr_q[AW-1:0]] = '{master: aw_master, len: aw_len};
    end

    // State registers; reset discards all pending entries
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            w_err_q <= 1'b0;
            for (int i = 0; i < depth; i++) mem_q[i] <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            w_err_q <= w_err_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: tb/tb_xbar_write_order_tracker.sv
// tb_xbar_write_order_tracker: scoreboard bench for the write order tracker (XBAR_WLAST_CHECK_EN optional)
module tb_xbar_write_order_tracker;

    localparam int MASTERS = 2;
    localparam int LW      = 4;
    localparam int DEPTH   = 4;
    localparam int MW      = 1;
    localparam int PW      = 3;

    logic          ACLK = 1'b0;
    logic          ARESETn = 1'b0;
    logic          aw_accept = 1'b0;
    logic [MW-1:0] aw_master = '0;
    logic [LW-1:0] aw_len = '0;
    logic          aw_block;
    logic          w_src_valid;
    logic [MW-1:0] w_src_master;
    logic          w_beat = 1'b0;
    logic          w_last = 1'b0;
    logic [PW-1:0] outstanding;
    logic          w_err;
    logic          err_clr = 1'b0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int m;
        int l;
    } ent_t;

    ent_t sb[$];
    int   mcnt = 0;
    bit   merr = 0;

    always #5 ACLK = ~ACLK;

    xbar_write_order_tracker #(.masters(MASTERS), .LEN_WIDTH(LW), .depth(DEPTH)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .aw_accept(aw_accept), .aw_master(aw_master), .aw_len(aw_len), .aw_block(aw_block),
        .w_src_valid(w_src_valid), .w_src_master(w_src_master),
        .w_beat(w_beat), .w_last(w_last), .outstanding(outstanding),
        .w_err(w_err), .err_clr(err_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".outstanding"}, 32'(outstanding), 32'(sb.size()));
        check({tag, ".aw_block"}, 32'(aw_block), 32'(sb.size() == DEPTH));
        check({tag, ".valid"}, 32'(w_src_valid), 32'(sb.size() > 0));
        check({tag, ".master"}, 32'(w_src_master), sb.size() > 0 ? 32'(sb[0].m) : 32'd0);
        check({tag, ".w_err"}, 32'(w_err), 32'(merr));
    endtask

    // One clock: drive inputs, compare head on consumption, advance the model, check after the edge
    task automatic cyc(input string tag, input bit acc, input int m, input int l,
                       input bit bt, input bit lst, input bit clr = 1'b0);
        bit valid, full, hit, retire, newerr;
        aw_accept = acc;
        aw_master = MW'(m);
        aw_len    = LW'(l);
        w_beat    = bt;
        w_last    = lst;
        err_clr   = clr;
        if (bt && sb.size() > 0) check({tag, ".head"}, 32'(w_src_master), 32'(sb[0].m));
        valid = sb.size() > 0;
        full  = sb.size() == DEPTH;
        hit   = valid && (mcnt == sb[0].l);
`ifdef XBAR_WLAST_CHECK_EN
        retire = bt && valid && (lst || hit);
        newerr = (bt && valid && (lst != hit)) || (bt && !valid);
        merr   = newerr || (merr && !clr);
`else
        retire = bt && valid && lst;
        newerr = 1'b0;
`endif
        if (retire) mcnt = 0;
        else if (bt && valid) mcnt++;
        if (retire) void'(sb.pop_front());
        if (acc && !full) sb.push_back('{m: m, l: l});
        @(posedge ACLK);
        #1;
        aw_accept = 1'b0;
        w_beat    = 1'b0;
        w_last    = 1'b0;
        err_clr   = 1'b0;
        check_state(tag);
    endtask

    task automatic do_reset();
        ARESETn = 1'b0;
        sb.delete();
        mcnt = 0;
        merr = 0;
        @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        @(posedge ACLK);
        #1;
    endtask

    initial begin
        do_reset();
        check_state("reset");

        // Single burst, master 1, len 3
        cyc("push1", 1, 1, 3, 0, 0);
        for (int i = 0; i < 4; i++) cyc("burst", 0, 0, 0, 1, i == 3);

        // Fill with 0,1,0,1 then a refused fifth push
        for (int i = 0; i < 4; i++) cyc("fill", 1, i % 2, 0, 0, 0);
        cyc("refused", 1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc("drain", 0, 0, 0, 1, 1);

        // Full queue with simultaneous push and retire: push refused
        for (int i = 0; i < 4; i++) cyc("refill", 1, (i + 1) % 2, 0, 0, 0);
        cyc("full_pr", 1, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) cyc("drain2", 0, 0, 0, 1, 1);

        // Beat while empty is ignored
        cyc("idle_beat", 0, 0, 0, 1, 1);

        // Pointer wrap with random masters
        for (int i = 0; i < 3 * DEPTH; i++) begin
            cyc("wrap_push", 1, int'($urandom_range(0, 1)), 0, 0, 0);
            cyc("wrap_pop", 0, 0, 0, 1, 1);
        end

        // Simultaneous push and retire with a non-full queue
        cyc("sp0", 1, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc("stream", 1, i % 2, 0, 1, 1);
        cyc("stream_end", 0, 0, 0, 1, 1);

`ifdef XBAR_WLAST_CHECK_EN
        // Early WLAST on beat 2 of a len-3 burst
        cyc("e_push", 1, 1, 3, 0, 0);
        cyc("e_b1", 0, 0, 0, 1, 0);
        cyc("e_b2", 0, 0, 0, 1, 1);
        cyc("e_clr", 0, 0, 0, 0, 0, 1);
        // Missing WLAST on beat 2 of a len-1 burst
        cyc("m_push", 1, 0, 1, 0, 0);
        cyc("m_b1", 0, 0, 0, 1, 0);
        cyc("m_b2", 0, 0, 0, 1, 0);
        cyc("m_clr", 0, 0, 0, 0, 0, 1);
        // New error wins over a clear
        cyc("w_empty", 0, 0, 0, 1, 0);
        cyc("w_win", 0, 0, 0, 1, 0, 1);
        cyc("w_clr", 0, 0, 0, 0, 0, 1);
`endif

        // Async reset mid-burst with three entries queued
        cyc("r_p0", 1, 1, 2, 0, 0);
        cyc("r_p1", 1, 0, 1, 0, 0);
        cyc("r_p2", 1, 1, 0, 0, 0);
        cyc("r_beat", 0, 0, 0, 1, 0);
        #3;
        ARESETn = 1'b0;
        #1;
        sb.delete();
        mcnt = 0;
        merr = 0;
        check_state("async_rst");
        @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        @(posedge ACLK);
        #1;
        check_state("post_rst");
        cyc("post_push", 1, 1, 0, 0, 0);
        cyc("post_pop", 0, 0, 0, 1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xbar_write_order_tracker.md
# xbar_write_order_tracker

Slave-side write steering unit for the crossbar, one instance per slave port. It replaces the single-burst write lock: up to `depth` accepted write-address transactions stay outstanding, and write data is steered from source masters strictly in AW acceptance order. It sits between the slave's write-address forward arbiter and its write-data FIFO push logic. It also supplies the master select for W-beat routing and back-pressure for AW forwarding.

## Interface
Parameters:
- `masters`, 2: number of crossbar masters; `MW = (masters>1) ? $clog2(masters) : 1`.
- `LEN_WIDTH`, 4: AWLEN width; burst beats = len+1.
- `depth`, 4: maximum outstanding write bursts; power of two, ≥2.

Ports:
- `ACLK` in 1: clock.
- `ARESETn` in 1: reset. One clock; reset is asynchronous and active-low.
- `aw_accept` in 1: an AW from the granted master enters the slave AW FIFO this cycle.
- `aw_master` in MW: master number of that AW.
- `aw_len` in LEN_WIDTH: AWLEN of that AW.
- `aw_block` out 1: order queue full; the AW arbiter must not push.
- `w_src_valid` out 1: a burst is at the queue head; W beats may be taken.
- `w_src_master` out MW: master whose W FIFO feeds the slave W FIFO.
- `w_beat` in 1: one W beat moved from `w_src_master` into the slave W FIFO.
- `w_last` in 1: WLAST of that beat.
- `outstanding` out $clog2(depth)+1: bursts queued, including the active head.
- `w_err` out 1: sticky protocol error; stays 0 when the check is compiled out.
- `err_clr` in 1: clears `w_err`.

## Operation
- Order queue is a circular FIFO of {master, len} entries with `depth` entries.
  - Read and write pointers are $clog2(depth)+1 bits; the MSB disambiguates full from empty.
  - Pointers wrap naturally at `depth`.
- Push: `aw_accept & ~aw_block` writes {aw_master, aw_len} at the write pointer.
  - `aw_accept` while `aw_block`=1 is ignored: no state change.
- Head outputs:
  - `w_src_valid` = queue not empty.
  - `w_src_master` = head master, or 0 when empty.
  - `aw_block` = queue full.
- Beat counter (LEN_WIDTH bits):
  - Increments on each `w_beat & w_src_valid`.
  - Clears when the burst retires.
- Retire, without the macro: `w_beat & w_src_valid & w_last` pops the head.
- `w_beat` while `w_src_valid`=0 is ignored.
- Simultaneous push and retire: the pointers move independently and `outstanding` is unchanged.
  - A push is still refused if the queue was full at the start of the cycle.
- `outstanding` = write pointer − read pointer, modulo 2^($clog2(depth)+1).

## Timing
- All outputs are registered or derived only from registered state; no input-to-output combinational paths.
- AW-to-W latency: `aw_accept` at cycle N into an empty queue gives `w_src_valid`=1 and a valid `w_src_master` from cycle N+1.
- Back-to-back bursts: a retire at cycle N exposes the next head at N+1.
  - A single-beat burst can therefore retire every cycle.
- `aw_block` rises in the cycle after the `depth`-th push.
  - It falls in the cycle after a retire from full.
- Reset: asserting `ARESETn`=0 at any time, including mid-burst, immediately clears:
  - pointers, beat counter and `w_err`;
  - all outputs to 0 (`aw_block`, `w_src_valid`, `w_src_master`, `outstanding`, `w_err`).
  - Pending entries are discarded.
- `err_clr` takes effect at the next edge.
  - A simultaneous new error wins: `w_err` stays 1.

## Configuration
- `XBAR_WLAST_CHECK_EN` defined: the beat counter is checked against the head len.
  - A burst retires on `w_beat & w_src_valid & (w_last | cnt==len)`.
  - `w_err` sets if `w_last != (cnt==len)` on any counted beat; this covers both early WLAST and missing WLAST.
  - `w_err` also sets on `w_beat` while the queue is empty.
- `XBAR_WLAST_CHECK_EN` undefined:
  - retire on `w_last` only;
  - no length compare logic;
  - `w_err` tied to 0 and `err_clr` unused.

## Test plan
- Reset, then push {master 1, len 3}: `w_src_valid`=1 and `w_src_master`=1 from the next cycle; 4 beats with `w_last` on the 4th retire the burst; `outstanding` goes 1→0.
- Push masters 0,1,0,1 (len 0 each) in 4 consecutive cycles with depth=4: `aw_block`=1, and a 5th `aw_accept` leaves `outstanding`=4. One beat per cycle then yields `w_src_master` sequence 0,1,0,1 and `aw_block`=0 after the first retire.
- Full queue with `aw_accept` and a retiring `w_beat` in the same cycle: the push is refused, `outstanding` goes 4→3, and the ordering of the remaining entries is unchanged.
- Pointer wrap: 3×depth alternating single push/retire pairs with random masters; `w_src_master` always matches the push order.
- `XBAR_WLAST_CHECK_EN`, len 3 with `w_last` on beat 2: the burst retires, `w_err`=1; `err_clr` brings it back to 0. Then len 1 without `w_last` on beat 2: the burst retires, `w_err`=1.
- Async reset asserted mid-burst with 3 entries queued: all outputs are 0 before the next ACLK edge, and after release `outstanding`=0.
